// File: rtl/line_dispatcher_pkg.sv
// Shared types and constants for the line dispatcher slice.
// Contents: screen half-extents, line command payload, dispatcher state encoding,
// off-screen test and saturating counter helpers.
package line_dispatcher_pkg;

  localparam int unsigned COORD_W = 13;
  localparam int unsigned COLOR_W = 4;
  localparam int unsigned CNT_W   = 16;

  localparam int HALF_WIDTH  = 320;
  localparam int HALF_HEIGHT = 240;

  // Visible window in centre-origin coordinates: [-HALF, HALF)
  localparam logic signed [COORD_W-1:0] X_LO = COORD_W'(-HALF_WIDTH);
  localparam logic signed [COORD_W-1:0] X_HI = COORD_W'(HALF_WIDTH);
  localparam logic signed [COORD_W-1:0] Y_LO = COORD_W'(-HALF_HEIGHT);
  localparam logic signed [COORD_W-1:0] Y_HI = COORD_W'(HALF_HEIGHT);

  typedef struct packed {
    logic signed [COORD_W-1:0] startX;
    logic signed [COORD_W-1:0] endX;
    logic signed [COORD_W-1:0] startY;
    logic signed [COORD_W-1:0] endY;
    logic [COLOR_W-1:0]        color;
    logic                      eof;
  } line_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    SWAP  = 2'd3
  } dispatch_state_t;

  // True when both endpoints lie beyond the same screen edge
  function automatic logic line_offscreen(line_cmd_t c);
    return ((c.startX <  X_LO) && (c.endX <  X_LO)) ||
           ((c.startX >= X_HI) && (c.endX >= X_HI)) ||
           ((c.startY <  Y_LO) && (c.endY <  Y_LO)) ||
           ((c.startY >= Y_HI) && (c.endY >= Y_HI));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/line_dispatcher_if.sv
// Command / rasterizer / framebuffer handshake bundle for line_dispatcher.
// master: vector-list walker + rasterizer + framebuffer side (drives commands,
//         rastReady/rastDone, swapAck). slave: the dispatcher.
interface line_dispatcher_if;
  import line_dispatcher_pkg::*;

  logic                      cmdValid;
  logic                      cmdReady;
  logic signed [COORD_W-1:0] cmdStartX;
  logic signed [COORD_W-1:0] cmdEndX;
  logic signed [COORD_W-1:0] cmdStartY;
  logic signed [COORD_W-1:0] cmdEndY;
  logic [COLOR_W-1:0]        cmdColor;
  logic                      cmdEof;

  logic                      rastReady;
  logic                      rastDone;
  logic                      readyIn;
  logic signed [COORD_W-1:0] startX;
  logic signed [COORD_W-1:0] endX;
  logic signed [COORD_W-1:0] startY;
  logic signed [COORD_W-1:0] endY;
  logic [COLOR_W-1:0]        lineColor;

  logic                      frameDone;
  logic                      swapAck;
  logic [CNT_W-1:0]          lineCount;
  logic [CNT_W-1:0]          cullCount;
  logic                      busy;

  modport master (
    output cmdValid, cmdStartX, cmdEndX, cmdStartY, cmdEndY, cmdColor, cmdEof,
    output rastReady, rastDone, swapAck,
    input  cmdReady, readyIn, startX, endX, startY, endY, lineColor,
    input  frameDone, lineCount, cullCount, busy
  );

  modport slave (
    input  cmdValid, cmdStartX, cmdEndX, cmdStartY, cmdEndY, cmdColor, cmdEof,
    input  rastReady, rastDone, swapAck,
    output cmdReady, readyIn, startX, endX, startY, endY, lineColor,
    output frameDone, lineCount, cullCount, busy
  );
endinterface

// File: rtl/line_cmd_fifo.sv
// Show-ahead synchronous FIFO for line commands.
// Ports: clk, rst (sync, active-high), push/din write side, pop/head read side,
// full/empty status. Push ignored when full, pop ignored when empty.
module line_cmd_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/line_dispatcher.sv
// Line dispatcher: buffers vector-list commands and launches them into the
// rasterizer one line at a time, stalling on end-of-frame until swapAck.
// Ports: clk, rst (sync, active-high), bus (line_dispatcher_if.slave) carrying
// the command handshake, rasterizer launch/done, frame swap and counters.
// Optional feature: define LINE_CULL_EN to drop lines entirely off-screen.
module line_dispatcher
  import line_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  line_dispatcher_if.slave bus
);
  localparam int unsigned CMD_W = $bits(line_cmd_t);

  dispatch_state_t state_q, state_d;

  line_cmd_t  cmd_in;
  line_cmd_t  head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       load;
  logic       frame_done;
  logic       cull_hit;

  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] cull_cnt_q, cull_cnt_d;
  logic             ready_q;

  logic signed [COORD_W-1:0] sx_q, ex_q, sy_q, ey_q;
  logic [COLOR_W-1:0]        col_q;

  // Command capture into the FIFO
  always_comb begin
    cmd_in        = '0;
    cmd_in.startX = bus.cmdStartX;
    cmd_in.endX   = bus.cmdEndX;
    cmd_in.startY = bus.cmdStartY;
    cmd_in.endY   = bus.cmdEndY;
    cmd_in.color  = bus.cmdColor;
    cmd_in.eof    = bus.cmdEof;
  end

  assign push = bus.cmdValid && !fifo_full;

  line_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef LINE_CULL_EN
  assign cull_hit = line_offscreen(head);
`else
  assign cull_hit = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      line_cnt_q <= '0;
      cull_cnt_q <= '0;
      ready_q    <= 1'b0;
      sx_q       <= '0;
      ex_q       <= '0;
      sy_q       <= '0;
      ey_q       <= '0;
      col_q      <= '0;
    end else begin
      state_q    <= state_d;
      line_cnt_q <= line_cnt_d;
      cull_cnt_q <= cull_cnt_d;
      // readyIn mirrors ISSUE without a decode cycle
      ready_q    <= (state_d == ISSUE);
      if (load) begin
        sx_q  <= head.startX;
        ex_q  <= head.endX;
        sy_q  <= head.startY;
        ey_q  <= head.endY;
        col_q <= head.color;
      end
    end
  end

  // Next-state, FIFO pop, output-register load and counter updates
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    load       = 1'b0;
    frame_done = 1'b0;
    line_cnt_d = line_cnt_q;
    cull_cnt_d = cull_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head.eof) begin
            frame_done = 1'b1;
            state_d    = SWAP;
          end else if (cull_hit) begin
            cull_cnt_d = sat_inc(cull_cnt_q);
          end else begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.rastReady) state_d = BUSY;
      end
      BUSY: begin
        if (bus.rastDone) begin
          state_d    = IDLE;
          line_cnt_d = sat_inc(line_cnt_q);
        end
      end
      SWAP: begin
        if (bus.swapAck) begin
          state_d    = IDLE;
          line_cnt_d = '0;
          cull_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cmdReady  = !fifo_full;
  assign bus.readyIn   = ready_q;
  assign bus.startX    = sx_q;
  assign bus.endX      = ex_q;
  assign bus.startY    = sy_q;
  assign bus.endY      = ey_q;
  assign bus.lineColor = col_q;
  // Pulses in the same cycle the end-of-frame marker is popped
  assign bus.frameDone = frame_done;
  assign bus.lineCount = line_cnt_q;
  assign bus.cullCount = cull_cnt_q;
  assign bus.busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_line_dispatcher.sv
module tb_line_dispatcher;
  import line_dispatcher_pkg::*;

`ifdef LINE_CULL_EN
  localparam bit CULL_ON = 1'b1;
`else
  localparam bit CULL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_dispatcher_if bus();

  line_dispatcher #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_lines = 0;
  int exp_culls = 0;
  int frame_pulses = 0;
  line_cmd_t exp_q[$];

  typedef struct {
    int sx; int ex; int sy; int ey; int col; bit cull;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input int sx, input int ex, input int sy, input int ey,
                           input int col, input bit eof, input bit enq);
    line_cmd_t e;
    bus.cmdValid  = 1'b1;
    bus.cmdStartX = COORD_W'(sx);
    bus.cmdEndX   = COORD_W'(ex);
    bus.cmdStartY = COORD_W'(sy);
    bus.cmdEndY   = COORD_W'(ey);
    bus.cmdColor  = COLOR_W'(col);
    bus.cmdEof    = eof;
    e.startX = COORD_W'(sx);
    e.endX   = COORD_W'(ex);
    e.startY = COORD_W'(sy);
    e.endY   = COORD_W'(ey);
    e.color  = COLOR_W'(col);
    e.eof    = eof;
    if (bus.cmdReady && enq) exp_q.push_back(e);
    step();
    bus.cmdValid = 1'b0;
    bus.cmdEof   = 1'b0;
  endtask

  // Wait (bounded) for readyIn, then let the rasterizer capture the line
  task automatic capture_line(output int waited);
    waited = 0;
    while (!bus.readyIn && waited < 20) begin
      step();
      waited++;
    end
    if (!bus.readyIn) begin
      fail("issue_timeout");
    end else begin
      bus.rastReady = 1'b1;
      step();
      bus.rastReady = 1'b0;
      chk("readyIn_after_capture", bus.readyIn, 0);
    end
  endtask

  task automatic finish_line(input int lat);
    repeat (lat - 1) step();
    chk("count_before_done", bus.lineCount, exp_lines);
    bus.rastDone = 1'b1;
    step();
    bus.rastDone = 1'b0;
    exp_lines++;
    chk("line_count", bus.lineCount, exp_lines);
  endtask

  task automatic run_line(input int lat, output int waited);
    capture_line(waited);
    finish_line(lat);
  endtask

  // Scoreboard: compare launched lines and frame markers in order
  always @(negedge clk) begin
    line_cmd_t e;
    if (!rst) begin
      if (bus.readyIn && bus.rastReady) begin
        if (exp_q.size() == 0) begin
          fail("sb_unexpected_issue");
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind_line", 0, e.eof);
          chk("sb_startX", $signed(bus.startX), e.startX);
          chk("sb_endX",   $signed(bus.endX),   e.endX);
          chk("sb_startY", $signed(bus.startY), e.startY);
          chk("sb_endY",   $signed(bus.endY),   e.endY);
          chk("sb_color",  bus.lineColor,       e.color);
        end
      end
      if (bus.frameDone) begin
        frame_pulses++;
        if (exp_q.size() == 0) begin
          fail("sb_unexpected_frameDone");
        end else begin
          e = exp_q.pop_front();
          chk("sb_kind_eof", 1, e.eof);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit cull_eff;

    //      sx     ex    sy    ey   col cull
    tbl[0]  = '{-10,    20,    5,   -7,  4, 1'b0};
    tbl[1]  = '{400,   500,    0,   10,  2, 1'b1};
    tbl[2]  = '{0,       1,    0,    1,  3, 1'b0};
    tbl[3]  = '{319,   319, -240,  239,  5, 1'b0};
    tbl[4]  = '{320,   320,    0,    0,  6, 1'b1};
    tbl[5]  = '{-321, -321,    0,    0,  7, 1'b1};
    tbl[6]  = '{-320, -321,    0,    0,  8, 1'b0};
    tbl[7]  = '{0,       0,  240,  300,  9, 1'b1};
    tbl[8]  = '{0,       0, -241, -500, 10, 1'b1};
    tbl[9]  = '{-4096, 4095, -4096, 4095, 15, 1'b0};
    tbl[10] = '{100,  -700,   10,   10,  1, 1'b0};

    rst = 1'b1;
    bus.cmdValid = 0; bus.cmdStartX = '0; bus.cmdEndX = '0; bus.cmdStartY = '0;
    bus.cmdEndY = '0; bus.cmdColor = '0; bus.cmdEof = 0;
    bus.rastReady = 0; bus.rastDone = 0; bus.swapAck = 0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_cmdReady",  bus.cmdReady, 1);
    chk("rst_readyIn",   bus.readyIn, 0);
    chk("rst_frameDone", bus.frameDone, 0);
    chk("rst_busy",      bus.busy, 0);
    chk("rst_lineCount", bus.lineCount, 0);
    chk("rst_cullCount", bus.cullCount, 0);
    chk("rst_startX",    $signed(bus.startX), 0);
    chk("rst_lineColor", bus.lineColor, 0);

    // Table-driven single lines, including culling boundaries
    for (int i = 0; i < 11; i++) begin
      cull_eff = tbl[i].cull && CULL_ON;
      push_line(tbl[i].sx, tbl[i].ex, tbl[i].sy, tbl[i].ey, tbl[i].col, 1'b0, !cull_eff);
      if (cull_eff) begin
        chk("cull_no_issue0", bus.readyIn, 0);
        step();
        exp_culls++;
        chk("cull_count", bus.cullCount, exp_culls);
        chk("cull_no_issue1", bus.readyIn, 0);
        step();
        chk("cull_idle", bus.busy, 0);
      end else begin
        run_line(6, w);
        chk("issue_latency", w, 1);
        chk("cull_count_hold", bus.cullCount, exp_culls);
      end
      if (i == 0) begin
        chk("t1_startX", $signed(bus.startX), -10);
        chk("t1_endY",   $signed(bus.endY), -7);
        chk("t1_color",  bus.lineColor, 4);
        chk("t1_lineCount", bus.lineCount, 1);
      end
    end

    // Stray rastDone / swapAck while idle are ignored
    bus.rastDone = 1'b1; step(); bus.rastDone = 1'b0;
    chk("stray_done", bus.lineCount, exp_lines);
    bus.swapAck = 1'b1; step(); bus.swapAck = 1'b0;
    chk("stray_swap", bus.lineCount, exp_lines);
    chk("stray_swap_cull", bus.cullCount, exp_culls);

    // Frame: three lines then end-of-frame, swap handshake
    frame_pulses = 0;
    push_line(11, 12, 13, 14, 1, 1'b0, 1'b1);
    push_line(-21, -22, -23, -24, 2, 1'b0, 1'b1);
    push_line(31, -32, 33, -34, 3, 1'b0, 1'b1);
    push_line(0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_line(3, w);
      if (i > 0) chk("done_to_issue", w, 1);
    end
    chk("frameDone_pulse", bus.frameDone, 1);
    chk("frame_lineCount", bus.lineCount, exp_lines);
    step();
    chk("frameDone_once", bus.frameDone, 0);
    chk("swap_busy", bus.busy, 1);
    chk("swap_cmdReady", bus.cmdReady, 1);
    push_line(41, 42, 43, 44, 5, 1'b0, 1'b1);
    step(); step();
    chk("swap_stall", bus.readyIn, 0);
    chk("frame_pulse_count", frame_pulses, 1);
    bus.swapAck = 1'b1; step(); bus.swapAck = 1'b0;
    exp_lines = 0;
    exp_culls = 0;
    chk("swap_lineCount", bus.lineCount, 0);
    chk("swap_cullCount", bus.cullCount, 0);
    run_line(2, w);
    chk("next_frame_latency", w, 1);

    // FIFO fill with the rasterizer busy
    push_line(100, 101, 102, 103, 6, 1'b0, 1'b1);
    capture_line(w);
    for (int i = 0; i < 16; i++) begin
      chk("fill_ready", bus.cmdReady, 1);
      push_line(i, i + 1, -i, -i - 1, i, 1'b0, 1'b1);
    end
    chk("fifo_full", bus.cmdReady, 0);
    push_line(999, 999, 999, 999, 15, 1'b0, 1'b1);
    chk("full_hold", bus.cmdReady, 0);
    finish_line(1);
    chk("full_in_idle", bus.cmdReady, 0);
    step();
    chk("ready_after_pop", bus.cmdReady, 1);
    chk("issue_after_full", bus.readyIn, 1);
    capture_line(w);
    finish_line(1);
    push_line(-200, 200, -100, 100, 9, 1'b0, 1'b1);
    chk("pushpop_occupancy", bus.cmdReady, 1);
    push_line(-201, 201, -101, 101, 10, 1'b0, 1'b1);
    chk("refill_full", bus.cmdReady, 0);
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) run_line(1, w);
    chk("fill_drained", exp_q.size(), 0);

    // Hold in ISSUE while the rasterizer is not ready
    push_line(-100, 50, 30, -30, 11, 1'b0, 1'b1);
    push_line(5, 6, 7, 8, 12, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_readyIn", bus.readyIn, 1);
      chk("hold_startX", $signed(bus.startX), -100);
      chk("hold_endY", $signed(bus.endY), -30);
      step();
    end
    run_line(2, w);
    run_line(2, w);

    // Reset while a line is in flight with five queued
    push_line(70, 71, 72, 73, 13, 1'b0, 1'b1);
    capture_line(w);
    for (int i = 0; i < 5; i++) push_line(80 + i, 81, 82, 83, 14, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_lines = 0;
    exp_culls = 0;
    chk("mid_rst_readyIn",  bus.readyIn, 0);
    chk("mid_rst_cmdReady", bus.cmdReady, 1);
    chk("mid_rst_busy",     bus.busy, 0);
    chk("mid_rst_lineCount", bus.lineCount, 0);
    chk("mid_rst_cullCount", bus.cullCount, 0);
    step();
    chk("post_rst_idle", bus.readyIn, 0);
    push_line(-1, -2, -3, -4, 7, 1'b0, 1'b1);
    run_line(2, w);
    chk("post_rst_latency", w, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
